// File: rtl/wb_store_buffer_if.sv
// Store-buffer bus bundle: writeback enqueue side, dcache drain side,
// and the memory-stage load-conflict lookup.
interface wb_store_buffer_if #(
   parameter int PTR_W = 2
);
   logic             WB_Final_Dcache_Write;
   logic [31:0]      WB_Final_Dcache_Address;
   logic [63:0]      WB_Final_Dcache_Data;
   logic [1:0]       WB_Final_datasize;
   logic             In_write_ready;
   logic             SB_Dcache_Write;
   logic [31:0]      SB_Dcache_Address;
   logic [63:0]      SB_Dcache_Data;
   logic [1:0]       SB_Dcache_Size;
   logic             Dcache_Write_Ack;
   logic             ME_Load_V;
   logic [31:0]      ME_Load_Address;
   logic             SB_Load_Conflict;
   logic             SB_Empty;
   logic [PTR_W:0]   SB_Count;

   // The store buffer itself
   modport slave (
      input  WB_Final_Dcache_Write, WB_Final_Dcache_Address,
             WB_Final_Dcache_Data, WB_Final_datasize,
             Dcache_Write_Ack, ME_Load_V, ME_Load_Address,
      output In_write_ready, SB_Dcache_Write, SB_Dcache_Address,
             SB_Dcache_Data, SB_Dcache_Size, SB_Load_Conflict,
             SB_Empty, SB_Count
   );

   // The surrounding pipeline / dcache
   modport master (
      output WB_Final_Dcache_Write, WB_Final_Dcache_Address,
             WB_Final_Dcache_Data, WB_Final_datasize,
             Dcache_Write_Ack, ME_Load_V, ME_Load_Address,
      input  In_write_ready, SB_Dcache_Write, SB_Dcache_Address,
             SB_Dcache_Data, SB_Dcache_Size, SB_Load_Conflict,
             SB_Empty, SB_Count
   );
endinterface

// File: rtl/wb_store_buffer.sv
// In-order store buffer between writeback and the dcache write port.
// Ready depends only on the registered count, so there is no
// combinational path from the dcache ack back to writeback.
module wb_store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic            CLK,
   input  logic            CLR,
   wb_store_buffer_if.slave sb
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [31:0]      addr_q [DEPTH];
   logic [63:0]      data_q [DEPTH];
   logic [1:0]       size_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;

   logic enq;
   logic deq;
   logic head_v;
   logic conflict;

   assign enq    = sb.WB_Final_Dcache_Write && (count_q != FULL_CNT);
   assign head_v = valid_q[head_q];
   assign deq    = head_v && sb.Dcache_Write_Ack;

   // Next-state for valid bits, pointers and occupancy
   always_comb begin
      valid_d = valid_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (enq) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + PTR_W'(1);
      end
      if (deq) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end
      if (enq && !deq) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (!enq && deq) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   // Control state with asynchronous reset; reset discards all entries
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage; no reset needed since outputs are gated by valid
   always_ff @(posedge CLK) begin
      if (enq) begin
         addr_q[tail_q] <= sb.WB_Final_Dcache_Address;
         data_q[tail_q] <= sb.WB_Final_Dcache_Data;
         size_q[tail_q] <= sb.WB_Final_datasize;
      end
   end

   // Qword-granular conflict against every valid entry, including one
   // that is being dequeued this cycle
   always_comb begin
      conflict = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (addr_q[i][31:3] == sb.ME_Load_Address[31:3])) begin
            conflict = 1'b1;
         end
      end
   end

   assign sb.In_write_ready    = (count_q != FULL_CNT);
   assign sb.SB_Dcache_Write   = head_v;
   assign sb.SB_Dcache_Address = head_v ? addr_q[head_q] : '0;
   assign sb.SB_Dcache_Data    = head_v ? data_q[head_q] : '0;
   assign sb.SB_Dcache_Size    = head_v ? size_q[head_q] : '0;
   assign sb.SB_Load_Conflict  = sb.ME_Load_V && conflict;
   assign sb.SB_Empty          = (count_q == '0);
   assign sb.SB_Count          = count_q;

endmodule

// File: tb/tb_wb_store_buffer.sv
// Scoreboard bench for wb_store_buffer: the stimulus side keeps a FIFO
// model of accepted stores; a negedge monitor compares the DUT against it.
module tb_wb_store_buffer;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   typedef struct {
      logic [31:0] a;
      logic [63:0] d;
      logic [1:0]  s;
   } st_t;

   logic clk;
   logic clr;
   wb_store_buffer_if #(.PTR_W(PTR_W)) bus ();

   wb_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .CLK (clk),
      .CLR (clr),
      .sb  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks   = 0;
   int   failures = 0;
   int   model_count = 0;
   st_t  exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.WB_Final_Dcache_Write   = 1'b0;
      bus.WB_Final_Dcache_Address = '0;
      bus.WB_Final_Dcache_Data    = '0;
      bus.WB_Final_datasize       = '0;
      bus.Dcache_Write_Ack        = 1'b0;
      bus.ME_Load_V               = 1'b0;
      bus.ME_Load_Address         = '0;
   endtask

   // Drive one cycle of inputs, then apply the FIFO rules to the model
   task automatic step(input logic wr, input logic [31:0] a, input logic [63:0] d,
                       input logic [1:0] s, input logic ack,
                       input logic ldv, input logic [31:0] la);
      bit do_enq, do_deq;
      st_t e;
      bus.WB_Final_Dcache_Write   = wr;
      bus.WB_Final_Dcache_Address = a;
      bus.WB_Final_Dcache_Data    = d;
      bus.WB_Final_datasize       = s;
      bus.Dcache_Write_Ack        = ack;
      bus.ME_Load_V               = ldv;
      bus.ME_Load_Address         = la;
      @(posedge clk);
      do_enq = wr && (model_count < DEPTH);
      do_deq = ack && (model_count > 0);
      if (do_enq) begin
         e.a = a; e.d = d; e.s = s;
         exp_q.push_back(e);
      end
      model_count = model_count + int'(do_enq) - int'(do_deq);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 64'(bus.In_write_ready), 64'd1);
      chk({tag, "_write"}, 64'(bus.SB_Dcache_Write), 64'd0);
      chk({tag, "_addr"},  64'(bus.SB_Dcache_Address), 64'd0);
      chk({tag, "_data"},  bus.SB_Dcache_Data, 64'd0);
      chk({tag, "_size"},  64'(bus.SB_Dcache_Size), 64'd0);
      chk({tag, "_empty"}, 64'(bus.SB_Empty), 64'd1);
      chk({tag, "_count"}, 64'(bus.SB_Count), 64'd0);
   endtask

   // Monitor: status, head presentation and load conflict vs. the model
   always @(negedge clk) begin
      if (clr) begin
         bit exp_conf;
         exp_conf = 1'b0;
         foreach (exp_q[i]) begin
            if (exp_q[i].a[31:3] == bus.ME_Load_Address[31:3]) exp_conf = 1'b1;
         end
         exp_conf = exp_conf && bus.ME_Load_V;
         chk("mon_count", 64'(bus.SB_Count), 64'(model_count));
         chk("mon_ready", 64'(bus.In_write_ready), 64'(model_count != DEPTH));
         chk("mon_empty", 64'(bus.SB_Empty), 64'(model_count == 0));
         chk("mon_write", 64'(bus.SB_Dcache_Write), 64'(model_count != 0));
         chk("mon_conflict", 64'(bus.SB_Load_Conflict), 64'(exp_conf));
         if (model_count != 0 && exp_q.size() != 0) begin
            chk("mon_head_addr", 64'(bus.SB_Dcache_Address), 64'(exp_q[0].a));
            chk("mon_head_data", bus.SB_Dcache_Data, exp_q[0].d);
            chk("mon_head_size", 64'(bus.SB_Dcache_Size), 64'(exp_q[0].s));
            if (bus.Dcache_Write_Ack) void'(exp_q.pop_front());
         end else if (model_count == 0) begin
            chk("mon_idle_addr", 64'(bus.SB_Dcache_Address), 64'd0);
            chk("mon_idle_data", bus.SB_Dcache_Data, 64'd0);
            chk("mon_idle_size", 64'(bus.SB_Dcache_Size), 64'd0);
         end
      end
   end

   initial begin
      logic [31:0] ra, rla;
      clr = 1'b0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1 clr = 1'b1;
      #1 chk_reset_outputs("rst");

      // Single store with ack held high
      step(1'b1, 32'h0000_1008, 64'h1122334455667788, 2'b10, 1'b1, 1'b0, '0);
      chk("single_write", 64'(bus.SB_Dcache_Write), 64'd1);
      chk("single_addr",  64'(bus.SB_Dcache_Address), 64'h1008);
      chk("single_data",  bus.SB_Dcache_Data, 64'h1122334455667788);
      step(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
      chk("single_empty", 64'(bus.SB_Empty), 64'd1);

      // Fill to full; the fifth store must be dropped
      for (int i = 0; i < 5; i++)
         step(1'b1, 32'h100 + 32'(i*8), {32'hA5A5_0000, 32'(i)}, 2'b01, 1'b0, 1'b0, '0);
      chk("full_count", 64'(bus.SB_Count), 64'd4);
      chk("full_ready", 64'(bus.In_write_ready), 64'd0);
      for (int i = 0; i < 5; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
      chk("drain_empty", 64'(bus.SB_Empty), 64'd1);

      // Simultaneous enqueue/dequeue at occupancy 2, pointers wrap
      for (int i = 0; i < 2; i++)
         step(1'b1, 32'h400 + 32'(i*8), 64'(64'hBEEF00 + i), 2'b00, 1'b0, 1'b0, '0);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 32'h500 + 32'(i*8), 64'(64'hCAFE00 + i), 2'b11, 1'b1, 1'b0, '0);
         chk("simul_count", 64'(bus.SB_Count), 64'd2);
      end
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);

      // Load conflict against a single buffered store at 0x2004
      step(1'b1, 32'h2004, 64'h0123, 2'b01, 1'b0, 1'b0, '0);
      bus.ME_Load_V = 1'b1; bus.ME_Load_Address = 32'h2000;
      #1 chk("ld_same_qword", 64'(bus.SB_Load_Conflict), 64'd1);
      bus.ME_Load_Address = 32'h2008;
      #1 chk("ld_next_qword", 64'(bus.SB_Load_Conflict), 64'd0);
      bus.ME_Load_V = 1'b0; bus.ME_Load_Address = 32'h2000;
      #1 chk("ld_not_valid", 64'(bus.SB_Load_Conflict), 64'd0);
      step(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);

      // Asynchronous reset mid-drain
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'h3000 + 32'(i*8), 64'(i + 7), 2'b10, 1'b0, 1'b0, '0);
      #1 clr = 1'b0;
      #1 chk_reset_outputs("midrst");
      exp_q.delete();
      model_count = 0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1 clr = 1'b1;
      #1 chk_reset_outputs("postrst");
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);

      // Randomized traffic over a small address window to exercise conflicts
      for (int i = 0; i < 500; i++) begin
         ra  = 32'h4000 + ($urandom_range(0, 15) << 2);
         rla = 32'h4000 + ($urandom_range(0, 15) << 2);
         step($urandom_range(0, 3) != 0, ra, {$urandom, $urandom},
              2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
              $urandom_range(0, 1) != 0, rla);
      end
      for (int i = 0; i < 6; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
      chk("final_empty", 64'(bus.SB_Empty), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
